regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_param.sv | 86 ++++++++
 tb/tb_regfile_param.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and flush FSM state type for the parameterised register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_param.sv
// Two-read/one-write register file with a DEPTH-cycle sequenced flush.
// Define REGFILE_BYPASS_EN to forward the write data to a same-address read.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             RegWrite,
  input  logic [AW-1:0]    Write_Register,
  input  logic [WIDTH-1:0] Reg_Write_Data,
  input  logic [AW-1:0]    Read_Register1,
  input  logic [AW-1:0]    Read_Register2,
  output logic [WIDTH-1:0] Read_Data1,
  output logic [WIDTH-1:0] Read_Data2,
  input  logic             Flush_Req,
  output logic             Busy
);

  logic [WIDTH-1:0] regs [DEPTH];
  state_t           state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt;

  assign Busy = (state == FLUSH);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (Flush_Req) begin
          state_nxt = FLUSH;
          idx_nxt   = '0;
        end
      end
      FLUSH: begin
        // AW-bit add wraps modulo DEPTH since DEPTH is a power of two
        idx_nxt = idx + AW'(1);
        if (idx == AW'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (Busy) begin
      regs[idx] <= '0;
    end else if (RegWrite) begin
      regs[Write_Register] <= Reg_Write_Data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = RegWrite && !Busy && Clear;

  always_comb begin
    Read_Data1 = regs[Read_Register1];
    Read_Data2 = regs[Read_Register2];
    if (fwd_ok && (Read_Register1 == Write_Register)) Read_Data1 = Reg_Write_Data;
    if (fwd_ok && (Read_Register2 == Write_Register)) Read_Data2 = Reg_Write_Data;
  end
`else
  assign Read_Data1 = regs[Read_Register1];
  assign Read_Data2 = regs[Read_Register2];
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: vector table, directed corner cases, random vs model.
module tb_regfile_param;

  localparam int W = 8;
  localparam int D = 4;

  logic         Clk, Clear, RegWrite, Flush_Req, Busy;
  logic [1:0]   Write_Register, Read_Register1, Read_Register2;
  logic [W-1:0] Reg_Write_Data, Read_Data1, Read_Data2;

  int nvec = 0;
  int miscompares = 0;

  regfile_param #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Clear(Clear), .RegWrite(RegWrite),
    .Write_Register(Write_Register), .Reg_Write_Data(Reg_Write_Data),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .Flush_Req(Flush_Req), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain array plus "flush in progress / next slot" bookkeeping.
  logic [W-1:0] m [D];
  bit           m_busy;
  int           m_idx;

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       fl;
    logic [1:0] r1, r2;
    logic [7:0] e1, e2;
    logic       eb;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [1:0] ra);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && !m_busy && Clear && ra == Write_Register) return Reg_Write_Data;
`endif
    return m[ra];
  endfunction

  task automatic model_edge();
    if (m_busy) begin
      m[m_idx] = '0;
      m_idx++;
      if (m_idx == D) m_busy = 0;
    end else begin
      if (RegWrite) m[Write_Register] = Reg_Write_Data;
      if (Flush_Req) begin
        m_busy = 1;
        m_idx  = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    RegWrite  = 1'b0;
    Flush_Req = 1'b0;
    Clear     = 1'b0;
    #1;
    for (int i = 0; i < D; i++) m[i] = '0;
    m_busy = 0;
    m_idx  = 0;
    chk("reset_busy", Busy, 0);
    for (int a = 0; a < D; a++) begin
      Read_Register1 = 2'(a);
      Read_Register2 = 2'(D - 1 - a);
      #1;
      chk("reset_rd1", Read_Data1, 0);
      chk("reset_rd2", Read_Data2, 0);
    end
    @(negedge Clk);
    Clear = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    RegWrite = 1'b1; Write_Register = a; Reg_Write_Data = d;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] e);
    Read_Register1 = a;
    #1;
    chk(name, Read_Data1, e);
  endtask

  initial begin
    Clear = 1'b0; RegWrite = 1'b0; Flush_Req = 1'b0;
    Write_Register = '0; Reg_Write_Data = '0;
    Read_Register1 = '0; Read_Register2 = '0;

    //            we    wa    wd     fl    r1    r2    e1     e2     eb
    tbl[0]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd2, 2'd0, 8'hA5, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 2'd2, 8'h11, 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 8'h22, 1'b0, 2'd1, 2'd0, 8'h22, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 2'd2, 8'h33, 1'b0, 2'd2, 2'd1, 8'h33, 8'h22, 1'b0};
    tbl[4]  = '{1'b1, 2'd3, 8'h44, 1'b0, 2'd3, 2'd2, 8'h44, 8'h33, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 8'h11, 8'h44, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 8'h00, 8'h22, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd2, 8'h00, 8'h33, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd3, 8'h00, 8'h44, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd0, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 2'd3, 8'hFF, 1'b0, 2'd3, 2'd1, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd2, 8'h00, 8'h00, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd0, 8'h00, 8'h00, 1'b1};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd1, 8'h00, 8'h00, 1'b0};

    #2;
    do_reset();

    // Table: drive write/flush across one edge, then read back with write disabled.
    for (int v = 0; v < 15; v++) begin
      RegWrite = tbl[v].we; Write_Register = tbl[v].wa;
      Reg_Write_Data = tbl[v].wd; Flush_Req = tbl[v].fl;
      tick();
      RegWrite = 1'b0; Flush_Req = 1'b0;
      Read_Register1 = tbl[v].r1; Read_Register2 = tbl[v].r2;
      #1;
      chk($sformatf("tbl%0d_rd1", v), Read_Data1, tbl[v].e1);
      chk($sformatf("tbl%0d_rd2", v), Read_Data2, tbl[v].e2);
      chk($sformatf("tbl%0d_busy", v), Busy, tbl[v].eb);
    end

    // Write into an already-cleared slot late in a flush must be dropped.
    wr(2'd0, 8'h5C); wr(2'd1, 8'h6D);
    Flush_Req = 1'b1; tick(); Flush_Req = 1'b0;
    tick(); tick();
    wr(2'd0, 8'hEE);
    chk_reg("drop_wr_reg0", 2'd0, 8'h00);
    tick();
    chk("drop_busy_end", Busy, 0);
    chk_reg("drop_wr_reg0_after", 2'd0, 8'h00);

    // Reset mid-flush.
    wr(2'd0, 8'h01); wr(2'd1, 8'h02); wr(2'd2, 8'h03); wr(2'd3, 8'h04);
    Flush_Req = 1'b1; tick(); Flush_Req = 1'b0;
    tick(); tick();
    Clear = 1'b0;
    #1;
    chk("midflush_busy", Busy, 0);
    for (int a = 0; a < D; a++) chk_reg($sformatf("midflush_reg%0d", a), 2'(a), 8'h00);
    @(negedge Clk); Clear = 1'b1;
    tick();
    chk("post_reset_busy", Busy, 0);
    wr(2'd1, 8'h5A);
    chk_reg("post_reset_wr", 2'd1, 8'h5A);

    // Same-cycle read of the register being written.
    wr(2'd0, 8'h10);
    RegWrite = 1'b1; Write_Register = 2'd0; Reg_Write_Data = 8'h3C; Read_Register1 = 2'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", Read_Data1, 8'h3C);
`else
    chk("bypass_same_cycle", Read_Data1, 8'h10);
`endif
    tick(); RegWrite = 1'b0;
    chk_reg("bypass_next_cycle", 2'd0, 8'h3C);

    // Flush request coincident with a write.
    RegWrite = 1'b1; Write_Register = 2'd0; Reg_Write_Data = 8'h77; Flush_Req = 1'b1;
    tick(); RegWrite = 1'b0; Flush_Req = 1'b0;
    chk("simul_busy", Busy, 1);
    chk_reg("simul_reg0_written", 2'd0, 8'h77);
    for (int c = 0; c < D; c++) tick();
    chk("simul_busy_end", Busy, 0);
    chk_reg("simul_reg0_cleared", 2'd0, 8'h00);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      RegWrite       = 1'($urandom_range(0, 1));
      Write_Register = 2'($urandom);
      Reg_Write_Data = 8'($urandom);
      Read_Register1 = 2'($urandom);
      Read_Register2 = 2'($urandom);
      Flush_Req      = ($urandom_range(0, 11) == 0);
      #1;
      chk("rnd_rd1", Read_Data1, exp_rd(Read_Register1));
      chk("rnd_rd2", Read_Data2, exp_rd(Read_Register2));
      chk("rnd_busy", Busy, m_busy);
      model_edge();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
